// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: pin synchronisers, clock deglitch filter,
// 11-bit frame deserialiser with odd-parity/stop check and a mid-frame timeout.
module ps2_rx_frame #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       RX_ERR,
    output logic       BUSY
);

    localparam int FW   = $clog2(FILTER_LEN + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    logic [1:0]    ck_sync_q;
    logic [1:0]    dt_sync_q;
    logic          ck_f_q;
    logic          ck_f_prev_q;
    logic [FW-1:0] flt_cnt_q;

    state_t          state_q,   state_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [9:0]      shift_q,   shift_d;
    logic [TO_W-1:0] to_cnt_q,  to_cnt_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            valid_q,   valid_d;
    logic            err_q,     err_d;

    logic fe;
    logic data_bit;

    // Filtered clock only flips after FILTER_LEN consecutive disagreeing samples.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ck_sync_q   <= 2'b11;
            dt_sync_q   <= 2'b11;
            ck_f_q      <= 1'b1;
            ck_f_prev_q <= 1'b1;
            flt_cnt_q   <= '0;
        end else begin
            ck_sync_q   <= {ck_sync_q[0], PS2_CLK};
            dt_sync_q   <= {dt_sync_q[0], PS2_DATA};
            ck_f_prev_q <= ck_f_q;
            if (ck_sync_q[1] != ck_f_q) begin
                if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
                    ck_f_q    <= ck_sync_q[1];
                    flt_cnt_q <= '0;
                end else begin
                    flt_cnt_q <= flt_cnt_q + 1'b1;
                end
            end else begin
                flt_cnt_q <= '0;
            end
        end
    end

    assign fe       = ck_f_prev_q & ~ck_f_q;
    assign data_bit = dt_sync_q[1];

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            to_cnt_q  <= '0;
            rx_data_q <= 8'h00;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            to_cnt_q  <= to_cnt_d;
            rx_data_q <= rx_data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        to_cnt_d  = to_cnt_q;
        rx_data_d = rx_data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                to_cnt_d = '0;
                if (fe && !data_bit) begin
                    state_d   = SHIFT;
                    bit_cnt_d = 4'd1;
                    shift_d   = '0;
                end
            end
            SHIFT: begin
                // The start bit is not stored: after ten shifts shift_q = {stop, P, D7..D0}.
                if (fe) begin
                    shift_d   = {data_bit, shift_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    to_cnt_d  = '0;
                    if (bit_cnt_q == 4'd10) begin
                        state_d = CHECK;
                    end
                end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    state_d   = IDLE;
                    err_d     = 1'b1;
                    to_cnt_d  = '0;
                    bit_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            CHECK: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
                if ((^shift_q[8:0]) && shift_q[9]) begin
                    rx_data_d = shift_q[7:0];
                    valid_d   = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign RX_DATA  = rx_data_q;
    assign RX_VALID = valid_q;
    assign RX_ERR   = err_q;
    assign BUSY     = (state_q == SHIFT);

endmodule
